// File: rtl/sys_ctrl_tx.sv
// Response serialiser: captures RF read data or ALU results and emits them as UART TX bytes.
// Optional trailing XOR checksum byte is built when SYS_CTRL_TX_CHECKSUM_EN is defined.
module sys_ctrl_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RF_RdData,
    input  logic                    RF_RdData_VLD,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    output logic [DATA_WIDTH-1:0]   UART_TX_DATA,
    output logic                    UART_TX_VLD,
    input  logic                    UART_TX_RDY,
    output logic                    BUSY,
    output logic                    OVERRUN
);

    localparam int DW = DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
`ifdef SYS_CTRL_TX_CHECKSUM_EN
        ,
        SEND_CK = 2'd3
`endif
    } state_t;

    state_t          state_q;
    state_t          state_nx;
    logic [2*DW-1:0] hold_q;
    logic [2*DW-1:0] hold_nx;
    logic            len2_q;
    logic            len2_nx;
    logic [DW-1:0]   data_nx;
    logic            vld_nx;
    logic            ovr_nx;
    logic            any_strobe;
    logic            accept;
    logic            drop;

`ifdef SYS_CTRL_TX_CHECKSUM_EN
    logic [DW-1:0]   ck_q;
    logic [DW-1:0]   ck_nx;
`endif

    // VLD is registered and mirrors state != IDLE, so it already encodes "byte on offer"
    assign any_strobe = RF_RdData_VLD | ALU_OUT_VLD;
    assign accept     = UART_TX_VLD & UART_TX_RDY;
    assign drop       = (state_q != IDLE) ? any_strobe : (RF_RdData_VLD & ALU_OUT_VLD);

    // State register and all registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            len2_q       <= 1'b0;
            UART_TX_DATA <= '0;
            UART_TX_VLD  <= 1'b0;
            BUSY         <= 1'b0;
            OVERRUN      <= 1'b0;
`ifdef SYS_CTRL_TX_CHECKSUM_EN
            ck_q         <= '0;
`endif
        end else begin
            state_q      <= state_nx;
            hold_q       <= hold_nx;
            len2_q       <= len2_nx;
            UART_TX_DATA <= data_nx;
            UART_TX_VLD  <= vld_nx;
            BUSY         <= vld_nx;
            OVERRUN      <= ovr_nx;
`ifdef SYS_CTRL_TX_CHECKSUM_EN
            ck_q         <= ck_nx;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE: begin
                if (any_strobe) state_nx = SEND_LO;
            end
            SEND_LO: begin
                if (accept) begin
                    if (len2_q) begin
                        state_nx = SEND_HI;
                    end else begin
`ifdef SYS_CTRL_TX_CHECKSUM_EN
                        state_nx = SEND_CK;
`else
                        state_nx = IDLE;
`endif
                    end
                end
            end
            SEND_HI: begin
                if (accept) begin
`ifdef SYS_CTRL_TX_CHECKSUM_EN
                    state_nx = SEND_CK;
`else
                    state_nx = IDLE;
`endif
                end
            end
`ifdef SYS_CTRL_TX_CHECKSUM_EN
            SEND_CK: begin
                if (accept) state_nx = IDLE;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    // Capture, checksum and next-output values; outputs are driven from the next state so
    // the first byte appears in the cycle right after the strobe
    always_comb begin
        hold_nx = hold_q;
        len2_nx = len2_q;
        if (state_q == IDLE) begin
            if (RF_RdData_VLD) begin
                hold_nx = {{DW{1'b0}}, RF_RdData};
                len2_nx = 1'b0;
            end else if (ALU_OUT_VLD) begin
                hold_nx = ALU_OUT;
                len2_nx = 1'b1;
            end
        end

`ifdef SYS_CTRL_TX_CHECKSUM_EN
        ck_nx = ck_q;
        if (state_q == IDLE) begin
            ck_nx = '0;
        end else if (accept) begin
            ck_nx = ck_q ^ UART_TX_DATA;
        end
`endif

        ovr_nx = OVERRUN | drop;
        vld_nx = (state_nx != IDLE);

        data_nx = '0;
        case (state_nx)
            SEND_LO: data_nx = hold_nx[DW-1:0];
            SEND_HI: data_nx = hold_nx[2*DW-1:DW];
`ifdef SYS_CTRL_TX_CHECKSUM_EN
            SEND_CK: data_nx = ck_nx;
`endif
            default: data_nx = '0;
        endcase
    end

endmodule
